spi_regctrl: RTL and testbench
==============================

# spi_regctrl

Parametrised SPI register controller for the radio front-end codec: the generalised successor of the fixed AD9866 control block. After reset it plays a parameter-supplied init table, then serves register write and read-back commands from the command slave bus. Frame widths, SCLK rate and table depth are parameters, and redundant writes can be suppressed through a shadow register file. It sits between the command decoder and the codec SPI pins.

## Interface
- ADDR_W, 5: register address width.
- DATA_W, 8: register data width.
- PAD_W, 2: zero bits between the R/W bit and the address. Frame width FW = 1+PAD_W+ADDR_W+DATA_W (16 by default).
- INIT_DEPTH, 20: number of init entries. Must be ≤ 2^ADDR_W.
- INIT_TABLE, all zero: packed INIT_DEPTH×(1+DATA_W) bits. Entry i is {wr_en, data} for address i; entry 0 occupies the LSBs.
- SCLK_DIV, 1: SCLK half-period in clk cycles (≥1).
- GAP_CYC, 1: minimum number of clk cycles sen_n stays high between frames (≥1).
- SKIP_REDUNDANT, 1: when 1, a write whose data equals a valid shadow entry is acknowledged without generating a frame.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_rqst  in  1  command request; held high until cmd_ack.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_W  register address.
- cmd_data  in  DATA_W  write data.
- cmd_ack  out  1  one-cycle pulse when the command is accepted.
- rd_data  out  DATA_W  read-back data. Holds its value until the next read completes.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- init_done  out  1  high once the init table has been played.
- busy  out  1  high while a frame or gap is in progress.
- spi_sclk  out  1  SPI clock.
- spi_sen_n  out  1  SPI chip enable, active low.
- spi_sdio  out  1  serial data to the codec, MSB first.
- spi_sdo  in  1  serial data from the codec.

## Operation
- Reset values:
  - spi_sen_n=1, spi_sclk=0, spi_sdio=0.
  - cmd_ack=0, rd_valid=0, rd_data=0, init_done=0, busy=0.
  - All shadow valid bits cleared.
- Frame format: {rw, PAD_W'b0, addr, data}, shifted MSB first. For reads, the data field is transmitted as 0.
- States:
  - INIT: index i scans 0..INIT_DEPTH-1, one cycle per entry. If wr_en=1, issue a write frame of {addr=i, data} and go to SHIFT, returning to INIT afterwards. After the last entry, set init_done and go to IDLE.
  - IDLE: when cmd_rqst=1, latch the command and pulse cmd_ack.
    - If it is a write, SKIP_REDUNDANT=1, shadow[addr] is valid and equal to cmd_data, stay in IDLE (no frame).
    - Otherwise go to SHIFT.
  - SHIFT: sen_n low. Each bit holds sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles. The shift register advances on the high→low transition. After FW bits, go to GAP.
  - GAP: sen_n high and sclk low for GAP_CYC cycles. Then return to INIT (if the table is unfinished) or IDLE.
- Read-back: during the last DATA_W bits of a read frame, spi_sdo is sampled on the clk edge that drives sclk high→low. At the end of the frame, rd_data receives the assembled byte and rd_valid pulses on the same cycle the state moves to GAP.
- Shadow: every write frame, from init or from a command, sets shadow[addr]=data and its valid bit. Reads and skipped writes leave the shadow unchanged.
- cmd_rqst is ignored (no ack) until init_done=1 and the state is IDLE. Requests wait; they are never dropped.

## Timing
- Command accept: cmd_ack rises the cycle after cmd_rqst is sampled high in IDLE. A skipped write acknowledges with the same latency and busy stays 0.
- Frame start: spi_sen_n falls and spi_sdio presents the MSB on the same edge that cmd_ack rises.
- Frame length: sen_n is low for exactly FW×2×SCLK_DIV cycles (32 cycles by default).
- Back-to-back commands: the next cmd_ack can occur no earlier than the cycle GAP exits. The minimum command-to-command period is FW×2×SCLK_DIV+GAP_CYC+1 cycles.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously). After rst_n is released, init restarts from entry 0.
- busy is high from the first sen_n-low cycle through the last GAP cycle.

## Test plan
- Default parameters, INIT_TABLE with only entries 4 (0x36) and 12 (0x43) enabled → exactly two frames, 0x0436 then 0x0C43; sen_n low for 32 cycles each; init_done rises after the second gap.
- After init, write addr 0x0A data 0x45 → cmd_ack one cycle after the request; SDIO carries 0x0A45; sen_n low for 32 cycles.
- Repeat the same write → cmd_ack pulses, no sen_n activity, busy stays 0. Then write 0x46 → a frame is generated.
- Read addr 0x05 with the codec model driving 0xA5 on spi_sdo → frame 0x8500 on SDIO; rd_data=0xA5 with a single rd_valid pulse.
- SCLK_DIV=3, GAP_CYC=4 → sclk high and low phases of 3 cycles each; sen_n low for 96 cycles; at least 4 high cycles between frames.
- Assert rst_n low at bit 7 of a frame → sen_n=1 and sclk=0 immediately; after release, init frames replay from entry 0.

Source files
------------

// File: rtl/spi_regctrl.sv
// SPI register controller: plays a parameterised init table after reset, then serves
// register write/read commands, with an optional shadow file to suppress redundant writes.
module spi_regctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PAD_W      = 2,
  parameter int unsigned INIT_DEPTH = 20,
  parameter logic [INIT_DEPTH*(DATA_W+1)-1:0] INIT_TABLE = '0,
  parameter int unsigned SCLK_DIV   = 1,
  parameter int unsigned GAP_CYC    = 1,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_rqst,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_sen_n,
  output logic              spi_sdio,
  input  logic              spi_sdo
);

  localparam int unsigned FW    = 1 + PAD_W + ADDR_W + DATA_W;
  localparam int unsigned EW    = DATA_W + 1;
  localparam int unsigned IDX_W = $clog2(INIT_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(FW);
  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned NREG  = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FW-1:0]     sr_q, sr_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sclk_q, sclk_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] shadow_q [NREG];
  logic [DATA_W-1:0] shadow_d [NREG];
  logic [NREG-1:0]   shv_q, shv_d;

  logic [IDX_W-1:0]  idx_sel;
  logic [EW-1:0]     entry;
  logic [DATA_W:0]   rx_cat;
  logic              skip;
  logic              load;
  logic              ld_rw;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  assign idx_sel = (idx_q < IDX_W'(INIT_DEPTH)) ? idx_q : '0;
  assign entry   = INIT_TABLE[32'(idx_sel)*EW +: EW];
  assign rx_cat  = {rx_q, spi_sdo};
  assign skip    = SKIP_REDUNDANT && !cmd_rw && shv_q[cmd_addr] &&
                   (shadow_q[cmd_addr] == cmd_data);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    div_d      = div_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    rw_d       = rw_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ack_d      = 1'b0;
    done_d     = done_q;
    shadow_d   = shadow_q;
    shv_d      = shv_q;
    load       = 1'b0;
    ld_rw      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;

    case (state_q)
      ST_INIT: begin
        if (idx_q == IDX_W'(INIT_DEPTH)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          if (entry[DATA_W]) begin
            load    = 1'b1;
            ld_addr = ADDR_W'(idx_q);
            ld_data = entry[DATA_W-1:0];
          end
        end
      end
      ST_IDLE: begin
        // ack_q guard keeps a still-held request from being accepted twice
        if (cmd_rqst && !ack_q) begin
          ack_d = 1'b1;
          if (!skip) begin
            load    = 1'b1;
            ld_rw   = cmd_rw;
            ld_addr = cmd_addr;
            ld_data = cmd_rw ? '0 : cmd_data;
          end
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            sr_d   = {sr_q[FW-2:0], 1'b0};
            bit_d  = bit_q + 1'b1;
            if (rw_q && (bit_q >= BIT_W'(FW - DATA_W))) rx_d = rx_cat[DATA_W-1:0];
            if (bit_q == BIT_W'(FW - 1)) begin
              state_d = ST_GAP;
              gap_d   = '0;
              if (rw_q) begin
                rd_data_d  = rx_cat[DATA_W-1:0];
                rd_valid_d = 1'b1;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = done_q ? ST_IDLE : ST_INIT;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_INIT;
    endcase

    if (load) begin
      state_d = ST_SHIFT;
      sr_d    = (FW'(ld_rw) << (FW - 1)) | (FW'(ld_addr) << DATA_W) | FW'(ld_data);
      bit_d   = '0;
      div_d   = '0;
      sclk_d  = 1'b0;
      rw_d    = ld_rw;
      if (!ld_rw) begin
        shadow_d[ld_addr] = ld_data;
        shv_d[ld_addr]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      sr_q       <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      shadow_q   <= '{default: '0};
      shv_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      rw_q       <= rw_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      shadow_q   <= shadow_d;
      shv_q      <= shv_d;
    end
  end

  assign cmd_ack   = ack_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = done_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign spi_sclk  = sclk_q;
  assign spi_sen_n = (state_q != ST_SHIFT);
  assign spi_sdio  = sr_q[FW-1];

endmodule

// File: tb/tb_spi_regctrl.sv
// Scoreboard bench for spi_regctrl: default instance for command/read/reset behaviour,
// plus a slow-SCLK instance for phase, frame-length and gap timing.
module tb_spi_regctrl;

  localparam int unsigned TBL_W = 20 * 9;
  localparam logic [TBL_W-1:0] TBL = (TBL_W'(9'h136) << 36) | (TBL_W'(9'h143) << 108);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_rqst, cmd_rw;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ack, rd_valid, init_done, busy;
  logic [7:0] rd_data;
  logic       spi_sclk, spi_sen_n, spi_sdio;
  logic       spi_sdo = 1'b0;

  logic       z1 = 1'b0;
  logic [4:0] z5 = '0;
  logic [7:0] z8 = '0;
  logic       ack3, rdv3, done3, busy3, sclk3, sen3, sdio3;
  logic [7:0] rdd3;

  spi_regctrl #(.INIT_TABLE(TBL)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_rqst(cmd_rqst), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done), .busy(busy),
    .spi_sclk(spi_sclk), .spi_sen_n(spi_sen_n), .spi_sdio(spi_sdio), .spi_sdo(spi_sdo)
  );

  spi_regctrl #(.INIT_TABLE(TBL), .SCLK_DIV(3), .GAP_CYC(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_rqst(z1), .cmd_rw(z1),
    .cmd_addr(z5), .cmd_data(z8), .cmd_ack(ack3),
    .rd_data(rdd3), .rd_valid(rdv3), .init_done(done3), .busy(busy3),
    .spi_sclk(sclk3), .spi_sen_n(sen3), .spi_sdio(sdio3), .spi_sdo(z1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  logic [15:0] exp_q[$];
  logic [15:0] exp3_q[$];
  logic [7:0]  rd_q[$];

  // Codec model: presents read data on the rising SCLK edge of each data bit.
  int         cbit = 0;
  logic [7:0] codec_byte = 8'h00;
  always @(negedge spi_sen_n or posedge spi_sclk) begin
    if (spi_sclk) begin
      if (!spi_sen_n) begin
        if (cbit >= 8) spi_sdo = codec_byte[15-cbit];
        cbit++;
      end
    end else begin
      cbit = 0;
    end
  end

  int          lo_cnt = 0, frames = 0, rdv_cnt = 0;
  logic [15:0] sh = '0;
  logic        p_sclk = 1'b0, p_sen = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      lo_cnt = 0; sh = '0; p_sclk = 1'b0; p_sen = 1'b1;
    end else begin
      if (!spi_sen_n) begin
        lo_cnt++;
        if (spi_sclk && !p_sclk) sh = {sh[14:0], spi_sdio};
      end else if (!p_sen) begin
        frames++;
        check("frame_len", lo_cnt, 32);
        check("sb_has_frame", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("frame_data", sh, exp_q.pop_front());
        lo_cnt = 0;
      end
      if (rd_valid) begin
        rdv_cnt++;
        check("sb_has_read", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rd_data", rd_data, rd_q.pop_front());
      end
      p_sclk = spi_sclk;
      p_sen  = spi_sen_n;
    end
  end

  int          lo3 = 0, run3 = 0, gap3 = 0, frames3 = 0;
  logic        have3 = 1'b0, p_sclk3 = 1'b0, p_sen3 = 1'b1;
  logic [15:0] sh3 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lo3 = 0; run3 = 0; gap3 = 0; have3 = 1'b0; p_sclk3 = 1'b0; p_sen3 = 1'b1; sh3 = '0;
    end else begin
      if (!sen3) begin
        if (p_sen3) begin
          if (have3) check("d3_gap_min", gap3 >= 4, 1);
          lo3 = 1; run3 = 1; sh3 = '0;
        end else begin
          lo3++;
          if (sclk3 != p_sclk3) begin
            check("d3_phase", run3, 3);
            run3 = 1;
          end else run3++;
        end
        if (sclk3 && !p_sclk3) sh3 = {sh3[14:0], sdio3};
      end else if (!p_sen3) begin
        frames3++;
        have3 = 1'b1;
        check("d3_len", lo3, 96);
        check("d3_last_phase", run3, 3);
        check("d3_sb_has_frame", exp3_q.size() != 0, 1);
        if (exp3_q.size() != 0) check("d3_frame_data", sh3, exp3_q.pop_front());
        gap3 = 1;
      end else begin
        gap3++;
      end
      p_sclk3 = sclk3;
      p_sen3  = sen3;
    end
  end

  task automatic do_cmd(input logic rw, input logic [4:0] a, input logic [7:0] d, output int lat);
    @(negedge clk);
    cmd_rqst = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cmd_ack && lat < 300);
    check("ack_seen", cmd_ack, 1);
    cmd_rqst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    check(tag, init_done, 1);
  endtask

  int lat, f0, r0, t1, t2;
  logic bs;

  initial begin
    rst_n = 1'b0; cmd_rqst = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sen_n", spi_sen_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_sdio", spi_sdio, 0);
    check("rst_ack", cmd_ack, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    check("d3_rst_sen_n", sen3, 1);

    exp_q.push_back(16'h0436);  exp_q.push_back(16'h0C43);
    exp3_q.push_back(16'h0436); exp3_q.push_back(16'h0C43);
    @(negedge clk) rst_n = 1'b1;
    wait_init("init_done_timeout");
    check("init_frames", frames, 2);
    check("init_busy", busy, 0);

    exp_q.push_back(16'h0A45);
    do_cmd(1'b0, 5'h0A, 8'h45, lat);
    check("wr_lat", lat, 1);
    check("wr_sen_low", spi_sen_n, 0);
    check("wr_msb", spi_sdio, 0);
    check("wr_busy", busy, 1);
    wait_idle();

    f0 = frames;
    do_cmd(1'b0, 5'h0A, 8'h45, lat);
    check("skip_lat", lat, 1);
    bs = 1'b0;
    repeat (40) begin
      @(negedge clk);
      bs = bs | busy | !spi_sen_n;
    end
    check("skip_no_activity", bs, 0);
    check("skip_frames", frames, f0);

    exp_q.push_back(16'h0A46);
    do_cmd(1'b0, 5'h0A, 8'h46, lat);
    check("wr2_lat", lat, 1);
    check("wr2_sen_low", spi_sen_n, 0);
    wait_idle();

    codec_byte = 8'hA5;
    exp_q.push_back(16'h8500);
    rd_q.push_back(8'hA5);
    r0 = rdv_cnt;
    do_cmd(1'b1, 5'h05, 8'h00, lat);
    check("rd_lat", lat, 1);
    check("rd_msb", spi_sdio, 1);
    wait_idle();
    check("rd_pulses", rdv_cnt - r0, 1);
    check("rd_hold", rd_data, 8'hA5);

    exp_q.push_back(16'h0111); exp_q.push_back(16'h0222);
    do_cmd(1'b0, 5'h01, 8'h11, lat);
    t1 = cyc;
    do_cmd(1'b0, 5'h02, 8'h22, lat);
    t2 = cyc;
    check("b2b_period", t2 - t1, 34);
    wait_idle();

    for (int i = 0; i < 1000 && !done3; i++) @(negedge clk);
    check("d3_init_done", done3, 1);
    check("d3_frames", frames3, 2);

    exp_q.push_back(16'h0333);
    do_cmd(1'b0, 5'h03, 8'h33, lat);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_sen_n", spi_sen_n, 1);
    check("midrst_sclk", spi_sclk, 0);
    check("midrst_sdio", spi_sdio, 0);
    check("midrst_busy", busy, 0);
    check("midrst_init_done", init_done, 0);
    exp_q.push_back(16'h0436);  exp_q.push_back(16'h0C43);
    exp3_q.push_back(16'h0436); exp3_q.push_back(16'h0C43);
    f0 = frames;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("replay_init_timeout");
    check("replay_frames", frames - f0, 2);

    exp_q.push_back(16'h0A46);
    do_cmd(1'b0, 5'h0A, 8'h46, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_frame", spi_sen_n, 0);
    wait_idle();

    for (int i = 0; i < 1000 && !done3; i++) @(negedge clk);
    check("d3_replay_done", done3, 1);
    check("exp_q_empty", exp_q.size(), 0);
    check("exp3_q_empty", exp3_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("d3_idle_outputs", {ack3, rdv3, busy3, rdd3}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
